// File: rtl/forth_mem.sv
// Boot-loading instruction/data memory for a small Forth CPU: a byte-serial loader fills imem, then releases cpu_reset.
// Optional FORTH_MEM_WFWD_EN selects write-first dmem reads on a same-address collision (read-first otherwise).
module forth_mem #(
  parameter int width       = 16,
  parameter int iaddr_width = 10,
  parameter int daddr_width = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [iaddr_width-1:0] iaddr,
  output logic [15:0]            idata,
  input  logic [daddr_width-1:0] daddr,
  input  logic [width-1:0]       ddata_write,
  output logic [width-1:0]       ddata_read,
  input  logic                   dwrite,
  input  logic                   ld_valid,
  input  logic [7:0]             ld_data,
  output logic                   ld_ready,
  output logic                   cpu_reset
);

  localparam int IDEPTH = 2 ** iaddr_width;
  localparam int DDEPTH = 2 ** daddr_width;
  localparam logic [15:0] NOP = 16'hE040;
  localparam logic [iaddr_width-1:0] IADDR_ONE = 1;

  typedef enum logic [2:0] {LEN_HI, LEN_LO, DAT_HI, DAT_LO, RUN} state_t;

  state_t                 state;
  logic [7:0]             len_hi_q;
  logic [7:0]             dat_hi_q;
  logic [15:0]            len_q;
  logic [15:0]            cnt;
  logic [iaddr_width-1:0] waddr;
  logic                   cpu_reset_q;
  logic                   ld_ready_q;

  logic [15:0] imem [0:IDEPTH-1];
  logic [width-1:0] dmem [0:DDEPTH-1];
  logic [15:0]      idata_p1;
  logic [width-1:0] ddata_p1;

  logic accept;
  logic imem_we;
  logic dmem_we;
  logic [15:0] len_word;
  logic [15:0] cnt_inc;

  assign accept   = ld_valid & ld_ready_q;
  assign imem_we  = accept && (state == DAT_LO);
  assign dmem_we  = dwrite & ~cpu_reset_q;
  assign len_word = {len_hi_q, ld_data};
  assign cnt_inc  = cnt + 16'd1;

  assign ld_ready  = ld_ready_q;
  assign cpu_reset = cpu_reset_q;
  // The CPU sees NOPs for as long as it is held in reset.
  assign idata      = cpu_reset_q ? NOP : idata_p1;
  assign ddata_read = ddata_p1;

  // Loader FSM: control registers reset, the byte/length holding registers do not.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= LEN_HI;
      waddr       <= '0;
      cnt         <= '0;
      cpu_reset_q <= 1'b1;
      ld_ready_q  <= 1'b1;
    end else if (accept) begin
      case (state)
        LEN_HI: begin
          len_hi_q <= ld_data;
          state    <= LEN_LO;
        end
        LEN_LO: begin
          len_q <= len_word;
          if (len_word == 16'd0) begin
            state       <= RUN;
            cpu_reset_q <= 1'b0;
            ld_ready_q  <= 1'b0;
          end else begin
            state <= DAT_HI;
          end
        end
        DAT_HI: begin
          dat_hi_q <= ld_data;
          state    <= DAT_LO;
        end
        DAT_LO: begin
          waddr <= waddr + IADDR_ONE;
          cnt   <= cnt_inc;
          if (cnt_inc == len_q) begin
            state       <= RUN;
            cpu_reset_q <= 1'b0;
            ld_ready_q  <= 1'b0;
          end else begin
            state <= DAT_HI;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // Stage p1: instruction memory, written by the loader, read by the CPU.
  always_ff @(posedge clk) begin
    if (imem_we) imem[waddr] <= {dat_hi_q, ld_data};
    idata_p1 <= imem[iaddr];
  end

  always_ff @(posedge clk) begin
    if (dmem_we) dmem[daddr] <= ddata_write;
  end

  // Stage p1: data memory read register.
  always_ff @(posedge clk) begin
    if (reset) begin
      ddata_p1 <= '0;
    end else begin
`ifdef FORTH_MEM_WFWD_EN
      if (dmem_we) ddata_p1 <= ddata_write;
      else         ddata_p1 <= dmem[daddr];
`else
      ddata_p1 <= dmem[daddr];
`endif
    end
  end

endmodule

// File: tb/tb_forth_mem.sv
// Directed bench for forth_mem: table of loader cycles plus hand-written imem/dmem sequences.
module tb_forth_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  iaddr;
  logic [15:0] idata;
  logic [7:0]  daddr;
  logic [15:0] ddata_write;
  logic [15:0] ddata_read;
  logic        dwrite;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic        cpu_reset;

  int checks = 0;
  int errors = 0;

  forth_mem #(.width(16), .iaddr_width(10), .daddr_width(8)) dut (
    .clk(clk), .reset(reset), .iaddr(iaddr), .idata(idata),
    .daddr(daddr), .ddata_write(ddata_write), .ddata_read(ddata_read), .dwrite(dwrite),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready), .cpu_reset(cpu_reset)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic       exp_rdy;
    logic       exp_crst;
  } row_t;

  row_t tbl [32];

  task automatic set_row(input int i, input logic r, input logic v, input logic [7:0] d,
                         input logic er, input logic ec);
    tbl[i] = '{r, v, d, er, ec};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      reset    = tbl[i].rst;
      ld_valid = tbl[i].valid;
      ld_data  = tbl[i].data;
      step();
      chk($sformatf("row%0d ld_ready", i), {31'd0, ld_ready}, {31'd0, tbl[i].exp_rdy});
      chk($sformatf("row%0d cpu_reset", i), {31'd0, cpu_reset}, {31'd0, tbl[i].exp_crst});
    end
    reset    = 1'b0;
    ld_valid = 1'b0;
    ld_data  = 8'h00;
  endtask

  task automatic read_i(input logic [9:0] a, input logic [15:0] exp, input string name);
    iaddr = a;
    step();
    chk(name, {16'd0, idata}, {16'd0, exp});
  endtask

  task automatic write_d(input logic [7:0] a, input logic [15:0] d);
    dwrite = 1'b1; daddr = a; ddata_write = d;
    step();
    dwrite = 1'b0;
  endtask

  task automatic read_d(input logic [7:0] a, input logic [15:0] exp, input string name);
    dwrite = 1'b0; daddr = a;
    step();
    chk(name, {16'd0, ddata_read}, {16'd0, exp});
  endtask

  initial begin
    reset = 1'b1; iaddr = '0; daddr = '0; ddata_write = '0; dwrite = 1'b0;
    ld_valid = 1'b0; ld_data = '0;

    // two-word load, then a byte offered in RUN
    set_row(0, 1, 0, 8'h00, 1, 1);
    set_row(1, 0, 1, 8'h00, 1, 1);
    set_row(2, 0, 1, 8'h02, 1, 1);
    set_row(3, 0, 1, 8'h12, 1, 1);
    set_row(4, 0, 1, 8'h34, 1, 1);
    set_row(5, 0, 1, 8'hAB, 1, 1);
    set_row(6, 0, 1, 8'hCD, 0, 0);
    set_row(7, 0, 1, 8'hFF, 0, 0);
    // zero-length load
    set_row(8, 1, 0, 8'h00, 1, 1);
    set_row(9, 0, 1, 8'h00, 1, 1);
    set_row(10, 0, 1, 8'h00, 0, 0);
    // ld_valid toggling with garbage on the idle cycles
    set_row(11, 1, 0, 8'h00, 1, 1);
    set_row(12, 0, 1, 8'h00, 1, 1);
    set_row(13, 0, 0, 8'hFF, 1, 1);
    set_row(14, 0, 1, 8'h01, 1, 1);
    set_row(15, 0, 0, 8'hFF, 1, 1);
    set_row(16, 0, 1, 8'hE0, 1, 1);
    set_row(17, 0, 0, 8'hFF, 1, 1);
    set_row(18, 0, 1, 8'h40, 0, 0);
    // aborted load of three words, then a zero-length load
    set_row(19, 1, 0, 8'h00, 1, 1);
    set_row(20, 0, 1, 8'h00, 1, 1);
    set_row(21, 0, 1, 8'h03, 1, 1);
    set_row(22, 0, 1, 8'h12, 1, 1);
    set_row(23, 0, 1, 8'h34, 1, 1);
    set_row(24, 1, 1, 8'h99, 1, 1);
    set_row(25, 0, 1, 8'h00, 1, 1);
    set_row(26, 0, 1, 8'h00, 0, 0);
    // fresh one-word load
    set_row(27, 1, 0, 8'h00, 1, 1);
    set_row(28, 0, 1, 8'h00, 1, 1);
    set_row(29, 0, 1, 8'h01, 1, 1);
    set_row(30, 0, 1, 8'h55, 1, 1);
    set_row(31, 0, 1, 8'h66, 0, 0);

    run_rows(0, 0);
    chk("reset idata", {16'd0, idata}, 32'h0000E040);
    chk("reset ddata_read", {16'd0, ddata_read}, 32'h0);
    run_rows(1, 7);
    read_i(10'd0, 16'h1234, "imem0 after load");
    read_i(10'd1, 16'hABCD, "imem1 after load");
    write_d(8'h05, 16'hBEEF);
    read_d(8'h05, 16'hBEEF, "dmem5 store/load");
    write_d(8'h07, 16'h2222);
    dwrite = 1'b1; daddr = 8'h07; ddata_write = 16'h1111;
    step();
    dwrite = 1'b0;
`ifdef FORTH_MEM_WFWD_EN
    chk("dmem7 collision", {16'd0, ddata_read}, 32'h00001111);
`else
    chk("dmem7 collision", {16'd0, ddata_read}, 32'h00002222);
`endif
    read_d(8'h07, 16'h1111, "dmem7 after write");

    run_rows(8, 10);
    read_i(10'd0, 16'h1234, "imem0 after empty load");

    run_rows(11, 18);
    read_i(10'd0, 16'hE040, "imem0 toggled load");
    read_i(10'd1, 16'hABCD, "imem1 retained");
    write_d(8'h09, 16'hAAAA);

    run_rows(19, 19);
    iaddr = 10'd1;
    step();
    chk("idata nop in load", {16'd0, idata}, 32'h0000E040);
    dwrite = 1'b1; daddr = 8'h09; ddata_write = 16'hDEAD;
    run_rows(20, 26);
    dwrite = 1'b0;
    read_i(10'd0, 16'h1234, "imem0 after abort");
    read_d(8'h09, 16'hAAAA, "dwrite ignored in load");

    run_rows(27, 31);
    read_i(10'd0, 16'h5566, "imem0 fresh load");
    read_i(10'd1, 16'hABCD, "imem1 after fresh load");
    read_d(8'h05, 16'hBEEF, "dmem kept over reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/forth_mem.md
FORTH_MEM -- requirements
Module: forth_mem

Interface
REQ-001 SHALL have parameter width, default 16, data word width.
REQ-002 SHALL have parameter iaddr_width, default 10, instruction address width (imem depth 2^iaddr_width words of 16 bits).
REQ-003 SHALL have parameter daddr_width, default 8, data address width (dmem depth 2^daddr_width words of width bits).
REQ-004 SHALL have ports:
  clk          in   1            clock
  reset        in   1            synchronous, active-high reset
  iaddr        in   iaddr_width  instruction fetch address from CPU
  idata        out  16           instruction word to CPU
  daddr        in   daddr_width  data address from CPU
  ddata_write  in   width        store data from CPU
  ddata_read   out  width        load data to CPU
  dwrite       in   1            store strobe from CPU
  ld_valid     in   1            loader byte valid
  ld_data      in   8            loader byte
  ld_ready     out  1            loader byte accept
  cpu_reset    out  1            hold CPU in reset while loading
REQ-005 SHALL state: reset reset, synchronous, active-high; clock clk.

Function
REQ-006 Loader FSM states SHALL be LEN_HI, LEN_LO, DAT_HI, DAT_LO, RUN.
REQ-007 A byte SHALL be accepted only in a cycle with ld_valid=1 and ld_ready=1; ld_ready SHALL be 1 in LEN_HI/LEN_LO/DAT_HI/DAT_LO, 0 in RUN.
REQ-008 LEN_HI->LEN_LO and LEN_LO->DAT_HI SHALL occur on accept; the two bytes form 16-bit word count N, big-endian.
REQ-009 If N=0 on the LEN_LO accept, FSM SHALL go directly to RUN.
REQ-010 DAT_HI->DAT_LO on accept, latching the high byte; DAT_LO accept SHALL write {hi,ld_data} to imem[waddr] in that same clock edge and increment waddr and word counter.
REQ-011 waddr SHALL start at 0 and wrap modulo 2^iaddr_width; N larger than the depth overwrites earlier words, no error.
REQ-012 After the DAT_LO accept of word N, FSM SHALL enter RUN; RUN SHALL be left only by reset.
REQ-013 cpu_reset SHALL be 1 in all states except RUN, and SHALL fall in the first cycle after RUN is entered.
REQ-014 idata SHALL be registered: idata at cycle t+1 = imem[iaddr sampled at t] (1-cycle latency).
REQ-015 While cpu_reset=1, idata SHALL be 16'hE040 (NOP).
REQ-016 dmem read SHALL be registered: ddata_read at t+1 = dmem[daddr at t].
REQ-017 When dwrite=1, dmem[daddr] SHALL be written with ddata_write at the clock edge; dwrite SHALL be ignored while cpu_reset=1.
REQ-018 ld_valid with ld_ready=0 SHALL be ignored with no state change; ld_data SHALL be don't-care when ld_valid=0.
REQ-019 Memory contents SHALL NOT be cleared by reset.

Reset
REQ-020 On reset: FSM=LEN_HI, waddr=0, word counter=0, cpu_reset=1, ld_ready=1, idata=16'hE040, ddata_read=0.
REQ-021 Reset mid-load SHALL abort the load; already-written imem words SHALL remain; next byte is LEN_HI.

Configuration
REQ-022 Macro FORTH_MEM_WFWD_EN: when defined, a dmem read of an address being written in the same cycle SHALL return the new ddata_write value next cycle (write-first).
REQ-023 When FORTH_MEM_WFWD_EN is undefined, the same case SHALL return the old stored value (read-first); all other behaviour identical.

Verification
REQ-024 Bytes 00 02 12 34 AB CD with ld_valid held 1 -> imem[0]=1234, imem[1]=ABCD, cpu_reset falls 1 cycle after 6th accept, ld_ready=0 after.
REQ-025 Bytes 00 00 -> RUN after 2nd accept, no imem write, cpu_reset=0 next cycle.
REQ-026 Load 00 01 E0 40 with ld_valid toggling 1/0 every cycle -> only valid cycles accepted, imem[0]=E040, 4 accepts total.
REQ-027 In RUN, iaddr=1 at t -> idata=ABCD at t+1; dwrite=1 daddr=05 ddata_write=BEEF at t, daddr=05 at t+1 -> ddata_read=BEEF at t+2.
REQ-028 dwrite=1 daddr=07 data=1111 with prior dmem[07]=2222, same-cycle read of 07 -> next ddata_read=1111 with FORTH_MEM_WFWD_EN, 2222 without.
REQ-029 Reset asserted after bytes 00 03 12 34 -> FSM LEN_HI, cpu_reset=1; imem[0]=1234 retained; fresh load 00 01 55 66 -> imem[0]=5566.
